// File: rtl/miriscv_mem_pkg.sv
// rtl/miriscv_mem_pkg.sv - shared types and constants for the miriscv memory arbiter
package miriscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } mem_state_t;

  localparam logic [2:0] MEM_SIZE_B  = 3'd0;
  localparam logic [2:0] MEM_SIZE_H  = 3'd1;
  localparam logic [2:0] MEM_SIZE_W  = 3'd2;
  localparam logic [2:0] MEM_SIZE_BU = 3'd4;
  localparam logic [2:0] MEM_SIZE_HU = 3'd5;

  localparam int CNT_W = 10;

endpackage

// File: rtl/miriscv_mem_timeout.sv
// rtl/miriscv_mem_timeout.sv - busy-cycle counter that flags a memory access as expired
module miriscv_mem_timeout
  import miriscv_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == LIMIT);

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - shares one variable-latency memory port between fetch and load/store
module miriscv_mem_arbiter
  import miriscv_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_rvalid_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [2:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_rvalid_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [2:0]  mem_size_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        stall_o,
  output logic        err_o
);

  mem_state_t  r_state;
  mem_state_t  w_state_next;
  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_done;
  logic        w_abort;
  logic        w_busy;
  logic        w_expired;
  logic        w_instr_elig;
  logic        w_data_elig;

  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_instr_rdata;
  logic [31:0] r_data_rdata;
  logic        r_instr_rvalid;
  logic        r_data_rvalid;
  logic        r_err;

  // A requester still holds req during its rvalid cycle; that stale req must not re-grant.
  assign w_instr_elig = instr_req_i & ~r_instr_rvalid;
  assign w_data_elig  = data_req_i & ~r_data_rvalid;
  assign w_busy       = (r_state != ST_IDLE);

  miriscv_mem_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_grant_i | w_grant_d),
    .en     (w_busy & ~mem_ready_i),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_data_elig) begin
          w_grant_d    = 1'b1;
          w_state_next = ST_BUSY_D;
        end else if (w_instr_elig) begin
          w_grant_i    = 1'b1;
          w_state_next = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // A response arriving on the expiry cycle still counts as a normal completion.
        if (mem_ready_i) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we           <= 1'b0;
      r_size         <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_instr_rdata  <= '0;
      r_data_rdata   <= '0;
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_instr_rvalid <= 1'b0;
      r_data_rvalid  <= 1'b0;
      r_err          <= 1'b0;
      if (w_grant_d) begin
        r_we    <= data_we_i;
        r_size  <= data_size_i;
        r_addr  <= data_addr_i;
        r_wdata <= data_we_i ? data_wdata_i : 32'd0;
      end else if (w_grant_i) begin
        r_we    <= 1'b0;
        r_size  <= MEM_SIZE_W;
        r_addr  <= instr_addr_i;
        r_wdata <= '0;
      end
      if (w_done || w_abort) begin
        r_err <= w_abort;
        if (r_state == ST_BUSY_I) begin
          r_instr_rvalid <= 1'b1;
          r_instr_rdata  <= w_abort ? 32'd0 : mem_rdata_i;
        end else begin
          r_data_rvalid <= 1'b1;
          if (w_abort) begin
            r_data_rdata <= '0;
          end else if (!r_we) begin
            r_data_rdata <= mem_rdata_i;
          end
        end
      end
    end
  end

  assign mem_req_o      = w_busy;
  assign mem_we_o       = w_busy & r_we;
  assign mem_size_o     = r_size;
  assign mem_addr_o     = r_addr;
  assign mem_wdata_o    = r_wdata;
  assign instr_rdata_o  = r_instr_rdata;
  assign instr_rvalid_o = r_instr_rvalid;
  assign data_rdata_o   = r_data_rdata;
  assign data_rvalid_o  = r_data_rvalid;
  assign err_o          = r_err;
  assign stall_o        = (instr_req_i & ~r_instr_rvalid) | (data_req_i & ~r_data_rvalid);

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// tb/tb_miriscv_mem_arbiter.sv - directed self-checking bench for miriscv_mem_arbiter
module tb_miriscv_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        instr_rvalid_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [2:0]  data_size_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_rvalid_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [2:0]  mem_size_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        stall_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  miriscv_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_rdata_o(instr_rdata_o), .instr_rvalid_o(instr_rvalid_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_size_i(data_size_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .data_rvalid_o(data_rvalid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0;
    data_size_i = 0; data_addr_i = 0; data_wdata_i = 0; mem_rdata_i = 0; mem_ready_i = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    cyc(); cyc(); mid();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %h exp 0", mem_req_o); end
    checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_instr_rvalid: got %h exp 0", instr_rvalid_o); end
    checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_data_rvalid: got %h exp 0", data_rvalid_o); end
    checks++; if (instr_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_instr_rdata: got %h exp 0", instr_rdata_o); end
    checks++; if (data_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_data_rdata: got %h exp 0", data_rdata_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %h exp 0", err_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %h exp 0", stall_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr_o); end
    reset = 0;
    cyc();
  endtask

  task automatic test_fetch();
    instr_req_i = 1; instr_addr_i = 32'h10; mid();
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL fetch_c0_stall: got %h exp 1", stall_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_c0_mem_req: got %h exp 0", mem_req_o); end
    cyc();
    mem_ready_i = 1; mem_rdata_i = 32'h00500093; mid();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL fetch_c1_mem_req: got %h exp 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h10) begin errors++; $display("FAIL fetch_c1_addr: got %h exp 10", mem_addr_o); end
    checks++; if (mem_size_o !== 3'd2) begin errors++; $display("FAIL fetch_c1_size: got %h exp 2", mem_size_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL fetch_c1_we: got %h exp 0", mem_we_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL fetch_c1_stall: got %h exp 1", stall_o); end
    cyc();
    mem_ready_i = 0; mem_rdata_i = 0; mid();
    checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL fetch_c2_rvalid: got %h exp 1", instr_rvalid_o); end
    checks++; if (instr_rdata_o !== 32'h00500093) begin errors++; $display("FAIL fetch_c2_rdata: got %h exp 00500093", instr_rdata_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL fetch_c2_stall: got %h exp 0", stall_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_c2_mem_req: got %h exp 0", mem_req_o); end
    cyc();
    instr_req_i = 0; mid();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_c3_stale_req_masked: got %h exp 0", mem_req_o); end
    checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL fetch_c3_rvalid: got %h exp 0", instr_rvalid_o); end
    cyc();
  endtask

  task automatic test_both();
    instr_req_i = 1; instr_addr_i = 32'h14;
    data_req_i = 1; data_we_i = 1; data_size_i = 3'd2; data_addr_i = 32'h100; data_wdata_i = 32'hDEADBEEF;
    mid();
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL both_c0_stall: got %h exp 1", stall_o); end
    cyc();
    mem_ready_i = 1; mem_rdata_i = 32'h0BAD0BAD; mid();
    checks++; if (mem_we_o !== 1'b1) begin errors++; $display("FAIL both_c1_we: got %h exp 1", mem_we_o); end
    checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL both_c1_addr: got %h exp 100", mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL both_c1_wdata: got %h exp deadbeef", mem_wdata_o); end
    checks++; if (mem_size_o !== 3'd2) begin errors++; $display("FAIL both_c1_size: got %h exp 2", mem_size_o); end
    cyc();
    mem_ready_i = 0; mem_rdata_i = 0; mid();
    checks++; if (data_rvalid_o !== 1'b1) begin errors++; $display("FAIL both_c2_data_rvalid: got %h exp 1", data_rvalid_o); end
    checks++; if (data_rdata_o !== 32'h0) begin errors++; $display("FAIL both_c2_store_rdata_kept: got %h exp 0", data_rdata_o); end
    checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL both_c2_instr_rvalid: got %h exp 0", instr_rvalid_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL both_c2_stall: got %h exp 1", stall_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL both_c2_mem_req: got %h exp 0", mem_req_o); end
    cyc();
    data_req_i = 0; data_we_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h00A00113; mid();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL both_c3_mem_req: got %h exp 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h14) begin errors++; $display("FAIL both_c3_addr: got %h exp 14", mem_addr_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL both_c3_we: got %h exp 0", mem_we_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL both_c3_wdata: got %h exp 0", mem_wdata_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL both_c3_stall: got %h exp 1", stall_o); end
    cyc();
    mem_ready_i = 0; mem_rdata_i = 0; mid();
    checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL both_c4_instr_rvalid: got %h exp 1", instr_rvalid_o); end
    checks++; if (instr_rdata_o !== 32'h00A00113) begin errors++; $display("FAIL both_c4_instr_rdata: got %h exp 00a00113", instr_rdata_o); end
    checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL both_c4_data_rvalid: got %h exp 0", data_rvalid_o); end
    cyc();
    instr_req_i = 0; mid();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL both_c5_mem_req: got %h exp 0", mem_req_o); end
    cyc();
  endtask

  task automatic test_load_latency();
    data_req_i = 1; data_we_i = 0; data_size_i = 3'd4; data_addr_i = 32'h200; data_wdata_i = 32'h55;
    cyc();
    mid();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL load_c1_mem_req: got %h exp 1", mem_req_o); end
    checks++; if (mem_size_o !== 3'd4) begin errors++; $display("FAIL load_c1_size: got %h exp 4", mem_size_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL load_c1_wdata: got %h exp 0", mem_wdata_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL load_c1_we: got %h exp 0", mem_we_o); end
    cyc();
    data_addr_i = 32'hFFFFFFFC; mid();
    checks++; if (mem_addr_o !== 32'h200) begin errors++; $display("FAIL load_c2_addr_held: got %h exp 200", mem_addr_o); end
    cyc();
    mem_ready_i = 1; mem_rdata_i = 32'h1234; mid();
    checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL load_c3_rvalid: got %h exp 0", data_rvalid_o); end
    cyc();
    mem_ready_i = 0; mem_rdata_i = 0; mid();
    checks++; if (data_rvalid_o !== 1'b1) begin errors++; $display("FAIL load_c4_rvalid: got %h exp 1", data_rvalid_o); end
    checks++; if (data_rdata_o !== 32'h1234) begin errors++; $display("FAIL load_c4_rdata: got %h exp 1234", data_rdata_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL load_c4_err: got %h exp 0", err_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL load_c4_mem_req: got %h exp 0", mem_req_o); end
    cyc();
    data_req_i = 0; mid();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL load_c5_no_dup_req: got %h exp 0", mem_req_o); end
    cyc();
  endtask

  task automatic test_timeout();
    data_req_i = 1; data_we_i = 0; data_size_i = 3'd2; data_addr_i = 32'h300;
    cyc();
    for (int c = 1; c <= 5; c++) begin
      mid();
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL timeout_c%0d_mem_req: got %h exp 1", c, mem_req_o); end
      checks++; if (data_rvalid_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL timeout_c%0d_early: rvalid %h err %h exp 0 0", c, data_rvalid_o, err_o); end
      cyc();
    end
    mid();
    checks++; if (data_rvalid_o !== 1'b1) begin errors++; $display("FAIL timeout_c6_rvalid: got %h exp 1", data_rvalid_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL timeout_c6_err: got %h exp 1", err_o); end
    checks++; if (data_rdata_o !== 32'h0) begin errors++; $display("FAIL timeout_c6_rdata: got %h exp 0", data_rdata_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL timeout_c6_mem_req: got %h exp 0", mem_req_o); end
    cyc();
    data_req_i = 0; mid();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL timeout_c7_err: got %h exp 0", err_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL timeout_c7_mem_req: got %h exp 0", mem_req_o); end
    cyc();
  endtask

  task automatic test_timeout_ready();
    instr_req_i = 1; instr_addr_i = 32'h40;
    cyc();
    for (int c = 1; c <= 4; c++) begin
      mid();
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL tready_c%0d_mem_req: got %h exp 1", c, mem_req_o); end
      cyc();
    end
    mem_ready_i = 1; mem_rdata_i = 32'hCAFEF00D;
    cyc();
    mem_ready_i = 0; mem_rdata_i = 0; mid();
    checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL tready_c6_rvalid: got %h exp 1", instr_rvalid_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tready_c6_err: got %h exp 0", err_o); end
    checks++; if (instr_rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL tready_c6_rdata: got %h exp cafef00d", instr_rdata_o); end
    cyc();
    instr_req_i = 0;
    cyc();
  endtask

  task automatic test_reset_mid();
    instr_req_i = 1; instr_addr_i = 32'h80;
    cyc();
    mid();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rstmid_c1_mem_req: got %h exp 1", mem_req_o); end
    cyc();
    reset = 1; instr_req_i = 0;
    cyc();
    reset = 0; mid();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_c3_mem_req: got %h exp 0", mem_req_o); end
    checks++; if (instr_rdata_o !== 32'h0) begin errors++; $display("FAIL rstmid_c3_rdata: got %h exp 0", instr_rdata_o); end
    cyc();
    for (int c = 4; c <= 6; c++) begin
      mem_ready_i = (c == 5); mem_rdata_i = (c == 5) ? 32'h00BADBAD : 32'h0;
      mid();
      checks++; if (mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b0 || err_o !== 1'b0) begin
        errors++; $display("FAIL rstmid_c%0d_quiet: req %h rvalid %h err %h exp 0 0 0", c, mem_req_o, instr_rvalid_o, err_o);
      end
      cyc();
    end
    mem_ready_i = 0; mem_rdata_i = 0;
    instr_req_i = 1; instr_addr_i = 32'h84;
    cyc();
    mem_ready_i = 1; mem_rdata_i = 32'h00000013; mid();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h84) begin errors++; $display("FAIL rstmid_refetch_req: req %h addr %h exp 1 84", mem_req_o, mem_addr_o); end
    cyc();
    mem_ready_i = 0; mem_rdata_i = 0; mid();
    checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL rstmid_refetch_rvalid: got %h exp 1", instr_rvalid_o); end
    checks++; if (instr_rdata_o !== 32'h00000013) begin errors++; $display("FAIL rstmid_refetch_rdata: got %h exp 13", instr_rdata_o); end
    cyc();
    instr_req_i = 0;
    cyc();
  endtask

  task automatic test_back_to_back();
    instr_req_i = 1; instr_addr_i = 32'h20;
    cyc();
    mem_ready_i = 1; mem_rdata_i = 32'h11;
    cyc();
    mem_ready_i = 0; mem_rdata_i = 0;
    data_req_i = 1; data_we_i = 0; data_size_i = 3'd1; data_addr_i = 32'h402;
    mid();
    checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL b2b_c2_instr_rvalid: got %h exp 1", instr_rvalid_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL b2b_c2_mem_req: got %h exp 0", mem_req_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL b2b_c2_stall: got %h exp 1", stall_o); end
    instr_req_i = 0;
    cyc();
    mem_ready_i = 1; mem_rdata_i = 32'hFFFF8000; mid();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL b2b_c3_mem_req: got %h exp 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h402) begin errors++; $display("FAIL b2b_c3_addr: got %h exp 402", mem_addr_o); end
    checks++; if (mem_size_o !== 3'd1) begin errors++; $display("FAIL b2b_c3_size: got %h exp 1", mem_size_o); end
    cyc();
    mem_ready_i = 0; mem_rdata_i = 0; mid();
    checks++; if (data_rvalid_o !== 1'b1) begin errors++; $display("FAIL b2b_c4_rvalid: got %h exp 1", data_rvalid_o); end
    checks++; if (data_rdata_o !== 32'hFFFF8000) begin errors++; $display("FAIL b2b_c4_rdata: got %h exp ffff8000", data_rdata_o); end
    cyc();
    data_req_i = 0;
    cyc();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_both();
    test_load_latency();
    test_timeout();
    test_timeout_ready();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
